// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: opcode encodings, instruction field
// positions and the fetch FSM state type.
package instruction_fetch_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int FIELD_WIDTH  = 8;

    // Instruction layout: opcode[27:24], A[23:16], B[15:8], C[7:0]
    localparam int OP_MSB  = 27;
    localparam int OP_LSB  = 24;
    localparam int TGT_MSB = 23;
    localparam int TGT_LSB = 16;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOP  = 4'h0,
        OP_JMP  = 4'h1,
        OP_CALL = 4'h2,
        OP_RET  = 4'h3,
        OP_BLE  = 4'h4
    } opcode_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_return_stack.sv
// Hardware return-address LIFO; top-of-stack is visible combinationally so a
// RET can redirect the PC in the same cycle it is decoded.
module instruction_fetch_return_stack #(
    parameter int ADDR_WIDTH  = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] din,
    output logic [ADDR_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0]       sp_reg;
    logic [SP_W-1:0]       sp_next;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      top_idx;

    assign full    = (sp_reg == SP_W'(STACK_DEPTH));
    assign empty   = (sp_reg == '0);
    assign wr_idx  = sp_reg[IDX_W-1:0];
    // Wraps to the last slot when empty; dout is meaningless then anyway.
    assign top_idx = sp_reg[IDX_W-1:0] - IDX_W'(1);
    assign dout    = mem[top_idx];

    always_comb begin
        sp_next = sp_reg;
        if (push && !full) begin
            sp_next = sp_reg + SP_W'(1);
        end else if (pop && !empty) begin
            sp_next = sp_reg - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sp_reg <= '0;
        end else begin
            sp_reg <= sp_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst && push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, forwards ROM words to execute, resolves JMP/CALL/RET
// locally and parks on BLE until execute reports the outcome.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    INSTR_WIDTH = 28,
    parameter int                    STACK_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic [ADDR_WIDTH-1:0]  oAddress,
    input  logic [INSTR_WIDTH-1:0] iInstruction,
    input  logic                   iStall,
    input  logic                   iBranchValid,
    input  logic                   iBranchTaken,
    output logic [INSTR_WIDTH-1:0] oInstruction,
    output logic                   oValid,
    output logic                   oStackOverflow,
    output logic                   oStackUnderflow
);

    localparam logic [INSTR_WIDTH-1:0] NOP_WORD =
        {OP_NOP, {(INSTR_WIDTH-OPCODE_WIDTH){1'b0}}};

    fetch_state_e state_reg, state_next;

    logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
    logic [INSTR_WIDTH-1:0]  instr_reg, instr_next;
    logic                    valid_reg, valid_next;
    logic                    ovf_reg, ovf_next;
    logic                    udf_reg, udf_next;

    logic [OPCODE_WIDTH-1:0] fetch_op;
    logic [ADDR_WIDTH-1:0]   fetch_target;
    logic [ADDR_WIDTH-1:0]   held_target;
    logic [ADDR_WIDTH-1:0]   pc_plus1;

    logic                    stack_push, stack_pop;
    logic [ADDR_WIDTH-1:0]   stack_top;
    logic                    stack_full, stack_empty;

    assign fetch_op     = iInstruction[OP_MSB:OP_LSB];
    assign fetch_target = ADDR_WIDTH'(iInstruction[TGT_MSB:TGT_LSB]);
    // In BR_WAIT the BLE being resolved is the one still parked in instr_reg.
    assign held_target  = ADDR_WIDTH'(instr_reg[TGT_MSB:TGT_LSB]);
    assign pc_plus1     = pc_reg + ADDR_WIDTH'(1);

    instruction_fetch_return_stack #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_return_stack (
        .clk  (Clock),
        .srst (Reset),
        .push (stack_push),
        .pop  (stack_pop),
        .din  (pc_plus1),
        .dout (stack_top),
        .full (stack_full),
        .empty(stack_empty)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (!iStall && fetch_op == OP_BLE) begin
                    state_next = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                if (iBranchValid) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        pc_next    = pc_reg;
        instr_next = instr_reg;
        valid_next = 1'b0;
        ovf_next   = ovf_reg;
        udf_next   = udf_reg;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (!iStall) begin
                    instr_next = iInstruction;
                    valid_next = 1'b1;
                    case (fetch_op)
                        OP_JMP: pc_next = fetch_target;
                        OP_CALL: begin
                            if (stack_full) begin
                                pc_next  = pc_plus1;
                                ovf_next = 1'b1;
                            end else begin
                                stack_push = 1'b1;
                                pc_next    = fetch_target;
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                pc_next  = pc_plus1;
                                udf_next = 1'b1;
                            end else begin
                                stack_pop = 1'b1;
                                pc_next   = stack_top;
                            end
                        end
                        OP_BLE:  pc_next = pc_reg;
                        default: pc_next = pc_plus1;
                    endcase
                end
            end
            ST_BR_WAIT: begin
                if (iBranchValid) begin
                    pc_next = iBranchTaken ? held_target : pc_plus1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_reg    <= RESET_PC;
            instr_reg <= NOP_WORD;
            valid_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            udf_reg   <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
            ovf_reg   <= ovf_next;
            udf_reg   <= udf_next;
        end
    end

    assign oAddress        = pc_reg;
    assign oInstruction    = instr_reg;
    assign oValid          = valid_reg;
    assign oStackOverflow  = ovf_reg;
    assign oStackUnderflow = udf_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a queue-based program model is checked
// against the DUT every cycle, plus hand-computed expectations per scenario.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic        iStall = 1'b0;
    logic        iBranchValid = 1'b0;
    logic        iBranchTaken = 1'b0;
    logic [27:0] oInstruction;
    logic        oValid;
    logic        oStackOverflow;
    logic        oStackUnderflow;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    logic [27:0] rom [0:65535];

    always #5 Clock = ~Clock;

    assign iInstruction = rom[oAddress];

    instruction_fetch #(
        .ADDR_WIDTH (16),
        .INSTR_WIDTH(28),
        .STACK_DEPTH(8),
        .RESET_PC   (16'd0)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .oAddress       (oAddress),
        .iInstruction   (iInstruction),
        .iStall         (iStall),
        .iBranchValid   (iBranchValid),
        .iBranchTaken   (iBranchTaken),
        .oInstruction   (oInstruction),
        .oValid         (oValid),
        .oStackOverflow (oStackOverflow),
        .oStackUnderflow(oStackUnderflow)
    );

    // Program-level model: a PC, a return-address queue and a "waiting" flag.
    logic [15:0] m_pc = '0;
    logic [15:0] m_stack [$];
    bit          m_wait = 1'b0;
    logic [27:0] m_instr = '0;
    logic        m_valid = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    always @(posedge Clock) begin
        logic [27:0] ins;
        if (Reset) begin
            m_pc    = 16'd0;
            m_stack.delete();
            m_wait  = 1'b0;
            m_instr = {OP_NOP, 24'd0};
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else if (m_wait) begin
            m_valid = 1'b0;
            if (iBranchValid) begin
                m_pc   = iBranchTaken ? {8'd0, m_instr[23:16]} : m_pc + 16'd1;
                m_wait = 1'b0;
            end
        end else if (iStall) begin
            m_valid = 1'b0;
        end else begin
            ins     = rom[m_pc];
            m_instr = ins;
            m_valid = 1'b1;
            case (ins[27:24])
                OP_JMP: m_pc = {8'd0, ins[23:16]};
                OP_CALL: begin
                    if (m_stack.size() == 8) begin
                        m_ovf = 1'b1;
                        m_pc  = m_pc + 16'd1;
                    end else begin
                        m_stack.push_back(m_pc + 16'd1);
                        m_pc = {8'd0, ins[23:16]};
                    end
                end
                OP_RET: begin
                    if (m_stack.size() == 0) begin
                        m_udf = 1'b1;
                        m_pc  = m_pc + 16'd1;
                    end else begin
                        m_pc = m_stack.pop_back();
                    end
                end
                OP_BLE:  m_wait = 1'b1;
                default: m_pc = m_pc + 16'd1;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (check_en) begin
            chk("model_addr",  {16'd0, oAddress}, {16'd0, m_pc});
            chk("model_valid", {31'd0, oValid}, {31'd0, m_valid});
            chk("model_instr", {4'd0, oInstruction}, {4'd0, m_instr});
            chk("model_ovf",   {31'd0, oStackOverflow}, {31'd0, m_ovf});
            chk("model_udf",   {31'd0, oStackUnderflow}, {31'd0, m_udf});
            $display("cyc addr=%0d valid=%0b instr=%07h ovf=%0b udf=%0b",
                     oAddress, oValid, oInstruction, oStackOverflow, oStackUnderflow);
        end
    end

    function automatic logic [27:0] mk(input logic [3:0] op, input logic [7:0] tgt);
        return {op, tgt, 16'h0000};
    endfunction

    task automatic fill_nops();
        for (int i = 0; i < 65536; i++) begin
            rom[i] = {OP_NOP, 8'(i), 16'(i)};
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic do_reset();
        Reset        = 1'b1;
        iStall       = 1'b0;
        iBranchValid = 1'b0;
        iBranchTaken = 1'b0;
        cyc(2);
        Reset = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [15:0] addr, input logic valid);
        chk({name, "_addr"}, {16'd0, oAddress}, {16'd0, addr});
        chk({name, "_valid"}, {31'd0, oValid}, {31'd0, valid});
    endtask

    initial begin
        // Sequential NOPs, oInstruction lags by one, iBranchValid in RUN ignored
        fill_nops();
        do_reset();
        check_en = 1'b1;
        chk_out("rst", 16'd0, 1'b0);
        chk("rst_instr", {4'd0, oInstruction}, {4'd0, OP_NOP, 24'd0});
        chk("rst_flags", {30'd0, oStackOverflow, oStackUnderflow}, 32'd0);
        cyc(1);
        chk_out("seq1", 16'd1, 1'b1);
        chk("seq1_lag", {24'd0, oInstruction[23:16]}, 32'd0);
        cyc(1);
        chk_out("seq2", 16'd2, 1'b1);
        chk("seq2_lag", {24'd0, oInstruction[23:16]}, 32'd1);
        iBranchValid = 1'b1;
        iBranchTaken = 1'b1;
        cyc(1);
        iBranchValid = 1'b0;
        iBranchTaken = 1'b0;
        chk_out("seq3_bv_ignored", 16'd3, 1'b1);

        // JMP loop 11 <-> 12
        fill_nops();
        rom[0]  = mk(OP_JMP, 8'd11);
        rom[12] = mk(OP_JMP, 8'd11);
        do_reset();
        cyc(1); chk_out("jmp_a", 16'd11, 1'b1);
        cyc(1); chk_out("jmp_b", 16'd12, 1'b1);
        cyc(1); chk_out("jmp_c", 16'd11, 1'b1);
        chk("jmp_instr", {4'd0, oInstruction}, {4'd0, OP_JMP, 8'd11, 16'h0});
        cyc(1); chk_out("jmp_d", 16'd12, 1'b1);

        // CALL 32 at 5, RET at 35; trailing RET at 6 proves the stack is empty
        fill_nops();
        rom[0]  = mk(OP_JMP, 8'd5);
        rom[5]  = mk(OP_CALL, 8'd32);
        rom[35] = mk(OP_RET, 8'd0);
        rom[6]  = mk(OP_RET, 8'd0);
        do_reset();
        cyc(1); chk_out("call_at5", 16'd5, 1'b1);
        cyc(1); chk_out("call_tgt", 16'd32, 1'b1);
        cyc(3); chk_out("call_ret", 16'd35, 1'b1);
        cyc(1); chk_out("ret_to6", 16'd6, 1'b1);
        chk("ret_flags", {30'd0, oStackOverflow, oStackUnderflow}, 32'd0);
        cyc(1); chk_out("empty_ret", 16'd7, 1'b1);
        chk("empty_udf", {31'd0, oStackUnderflow}, 32'd1);

        // BLE 46 at 48: taken, then not taken
        fill_nops();
        rom[0]  = mk(OP_JMP, 8'd48);
        rom[48] = mk(OP_BLE, 8'd46);
        do_reset();
        cyc(1); chk_out("ble_fetch", 16'd48, 1'b1);
        cyc(1); chk_out("ble_issue", 16'd48, 1'b1);
        chk("ble_instr", {4'd0, oInstruction}, {4'd0, OP_BLE, 8'd46, 16'h0});
        cyc(1); chk_out("ble_bub1", 16'd48, 1'b0);
        iBranchValid = 1'b1;
        iBranchTaken = 1'b1;
        cyc(1); chk_out("ble_bub2", 16'd46, 1'b0);
        iBranchValid = 1'b0;
        iBranchTaken = 1'b0;
        cyc(1); chk_out("ble_taken", 16'd47, 1'b1);
        cyc(2); chk_out("ble2_issue", 16'd48, 1'b1);
        cyc(1);
        iBranchValid = 1'b1;
        iBranchTaken = 1'b0;
        cyc(1); chk_out("ble_not_taken", 16'd49, 1'b0);
        iBranchValid = 1'b0;
        cyc(1);

        // Nine nested CALLs at 0,10,..,80; RETs at 81,71,..,1
        fill_nops();
        for (int i = 0; i < 9; i++) begin
            rom[i*10]     = mk(OP_CALL, 8'((i+1)*10));
            rom[i*10 + 1] = mk(OP_RET, 8'd0);
        end
        do_reset();
        cyc(8); chk_out("nest8", 16'd80, 1'b1);
        chk("nest8_ovf", {31'd0, oStackOverflow}, 32'd0);
        cyc(1); chk_out("nest9", 16'd81, 1'b1);
        chk("nest9_ovf", {31'd0, oStackOverflow}, 32'd1);
        cyc(1); chk_out("unwind1", 16'd71, 1'b1);
        cyc(7); chk_out("unwind8", 16'd1, 1'b1);
        chk("unwind8_udf", {31'd0, oStackUnderflow}, 32'd0);
        cyc(1); chk_out("underflow", 16'd2, 1'b1);
        chk("underflow_flags", {30'd0, oStackOverflow, oStackUnderflow}, 32'd3);

        // Three stall cycles
        fill_nops();
        do_reset();
        cyc(2);
        iStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk_out("stall", 16'd2, 1'b0);
            chk("stall_instr", {24'd0, oInstruction[23:16]}, 32'd1);
        end
        iStall = 1'b0;
        cyc(1); chk_out("unstall", 16'd3, 1'b1);
        chk("unstall_instr", {24'd0, oInstruction[23:16]}, 32'd2);

        // Reset while parked in BR_WAIT with a sticky flag set
        fill_nops();
        rom[0]  = mk(OP_RET, 8'd0);
        rom[1]  = mk(OP_JMP, 8'd48);
        rom[48] = mk(OP_BLE, 8'd46);
        do_reset();
        cyc(1); chk("pre_udf", {31'd0, oStackUnderflow}, 32'd1);
        cyc(2); chk_out("pre_wait", 16'd48, 1'b1);
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        chk_out("brw_rst", 16'd0, 1'b0);
        chk("brw_rst_flags", {30'd0, oStackOverflow, oStackUnderflow}, 32'd0);
        cyc(1); chk_out("brw_run", 16'd1, 1'b1);
        cyc(2);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
